// File: rtl/wb_stage_reg.sv
// ---------------------------------------------------------------------------
// wb_stage_reg
//
// MEM->WB pipeline register for the 5-stage MIPS core. It captures the M-stage
// slot and produces the register-file write port (wa_w / we_w / wd_w). The same
// three signals also feed the W->D/E forwarding path.
//
// Beyond the plain latch it provides:
//   - stall (hold) and flush (bubble) control
//   - a valid bit, so bubbles can never write the register file
//   - byte/half/word load extraction with zero or sign extension
//   - the write-back source mux
//   - a counter of retired instructions
//
// Parameters
//   DATA_W  datapath width. Load extraction assumes 32.
//   RA_W    register address width
//   CNT_W   retired-instruction counter width (wraps modulo 2^CNT_W)
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   stall         hold all W contents this cycle
//   flush         load a bubble this cycle (wins over stall)
//   valid_m       M slot holds a real instruction
//   instr_m       M instruction word (kept for trace/debug)
//   pc8_m         PC+8 link value
//   aluout_m      ALU result / memory address (low 2 bits = load byte offset)
//   dm_m          raw aligned word read from data memory
//   wa_m          destination register
//   regwrite_m    instruction writes a GPR
//   wbsel_m       0 ALU, 1 load, 2 PC+8, 3 zero
//   ldtype_m      0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh, 5-7 lw
//   valid_w       W slot valid
//   instr_w       registered instruction
//   wa_w          write address
//   we_w          GPR write enable (valid, regwrite, and not $zero)
//   wd_w          write data
//   retired       count of valid instructions accepted into W
//
// Flow control: there is no ready signal. A slot moves from M into W on every
// edge where neither stall nor flush is asserted. valid_m only marks whether
// that slot is a real instruction. An accepted slot with valid_m = 1 counts as
// retired exactly once.
// ---------------------------------------------------------------------------
module wb_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_m,
  input  logic [31:0]       instr_m,
  input  logic [DATA_W-1:0] pc8_m,
  input  logic [DATA_W-1:0] aluout_m,
  input  logic [DATA_W-1:0] dm_m,
  input  logic [RA_W-1:0]   wa_m,
  input  logic              regwrite_m,
  input  logic [1:0]        wbsel_m,
  input  logic [2:0]        ldtype_m,
  output logic              valid_w,
  output logic [31:0]       instr_w,
  output logic [RA_W-1:0]   wa_w,
  output logic              we_w,
  output logic [DATA_W-1:0] wd_w,
  output logic [CNT_W-1:0]  retired
);

  // Write-back source selector encoding.
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC8  = 2'd2;

  // Load type encoding. Codes 5-7 behave as lw.
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic              r_valid;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_pc8;
  logic [DATA_W-1:0] r_aluout;
  logic [DATA_W-1:0] r_dm;
  logic [RA_W-1:0]   r_wa;
  logic              r_regwrite;
  logic [1:0]        r_wbsel;
  logic [2:0]        r_ldtype;
  logic [CNT_W-1:0]  r_retired;

  // Priority is rst > flush > stall > load.
  // flush clears the slot exactly as reset does, but the counter keeps its
  // value. A flush therefore discards the slot without un-retiring anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc8      <= '0;
      r_aluout   <= '0;
      r_dm       <= '0;
      r_wa       <= '0;
      r_regwrite <= 1'b0;
      r_wbsel    <= '0;
      r_ldtype   <= '0;
      r_retired  <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc8      <= '0;
      r_aluout   <= '0;
      r_dm       <= '0;
      r_wa       <= '0;
      r_regwrite <= 1'b0;
      r_wbsel    <= '0;
      r_ldtype   <= '0;
    end else if (!stall) begin
      r_valid    <= valid_m;
      r_instr    <= instr_m;
      r_pc8      <= pc8_m;
      r_aluout   <= aluout_m;
      r_dm       <= dm_m;
      r_wa       <= wa_m;
      r_regwrite <= regwrite_m;
      r_wbsel    <= wbsel_m;
      r_ldtype   <= ldtype_m;
      if (valid_m) begin
        r_retired <= r_retired + 1'b1;   // wraps naturally at 2^CNT_W
      end
    end
  end

  // -------------------------------------------------------------------------
  // Load extraction (little-endian, offset from registered address)
  // -------------------------------------------------------------------------
  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;

  assign w_off = r_aluout[1:0];

  always_comb begin
    w_byte = r_dm[7:0];
    case (w_off)
      2'd0: w_byte = r_dm[7:0];
      2'd1: w_byte = r_dm[15:8];
      2'd2: w_byte = r_dm[23:16];
      2'd3: w_byte = r_dm[31:24];
      default: w_byte = r_dm[7:0];
    endcase
  end

  // Halfword accesses ignore off[0]. A misaligned lh behaves like the
  // aligned one that contains it. Alignment faults are raised upstream.
  assign w_half = w_off[1] ? r_dm[31:16] : r_dm[15:0];

  always_comb begin
    w_load = r_dm;
    case (r_ldtype)
      LD_LBU:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
      LD_LB:   w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_LHU:  w_load = {{(DATA_W-16){1'b0}}, w_half};
      LD_LH:   w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      default: w_load = r_dm;
    endcase
  end

  // -------------------------------------------------------------------------
  // Write-back mux and write enable
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] w_wd;
  logic              w_we;

  always_comb begin
    w_wd = '0;
    case (r_wbsel)
      WB_ALU:  w_wd = r_aluout;
      WB_LOAD: w_wd = w_load;
      WB_PC8:  w_wd = r_pc8;
      default: w_wd = '0;
    endcase
  end

  // A bubble never writes, and neither does a write to $zero. Suppressing
  // the $zero write here also keeps forwarding from returning a nonzero $zero.
  assign w_we = r_valid & r_regwrite & (r_wa != '0);

  assign valid_w = r_valid;
  assign instr_w = r_instr;
  assign wa_w    = r_wa;
  assign we_w    = w_we;
  assign wd_w    = w_wd;
  assign retired = r_retired;

endmodule
